// File: rtl/scanout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scanout_pkg
// Description : Shared constants and state encoding for the scanout burst
//               reader (f2h_sdram frame-buffer streamer).
//               ADDR_W    - word address width (64-bit words)
//               DATA_W    - SDRAM / stream data width
//               BURST_LEN - largest Avalon-MM burst issued, in words
//               BC_W      - width of avm_burstcount
// Revision    : 1.0 - initial release
// ============================================================================
package scanout_pkg;

    localparam int ADDR_W    = 29;
    localparam int DATA_W    = 64;
    localparam int BURST_LEN = 32;
    localparam int BC_W      = 8;

    // Sequencer state encoding
    typedef logic [1:0] state_t;

    localparam state_t IDLE       = 2'd0;
    localparam state_t WAIT_SPACE = 2'd1;
    localparam state_t REQ        = 2'd2;
    localparam state_t DRAIN      = 2'd3;

endpackage : scanout_pkg
`default_nettype wire

// File: rtl/scanout_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scanout_fifo
// Description : Synchronous first-word-fall-through FIFO with a registered
//               output stage. The output register is the head entry, so a
//               word written into an empty FIFO is presented on rd_valid on
//               the following cycle. count reports every stored word,
//               including the one held in the output register.
// Ports       : clk, reset    - clock, asynchronous active-high reset
//               wr_en/wr_data - push (caller guarantees space)
//               rd_valid/rd_ready/rd_data - valid/ready pop side
//               count         - words held (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    logic w_pop;
    logic w_mem_empty;
    logic w_to_out;
    logic w_to_mem;
    logic w_refill;

    always_comb begin
        w_pop       = r_valid && rd_ready;
        w_mem_empty = (r_wr_ptr == r_rd_ptr);
        // A write bypasses the array only when nothing queued is ahead of it
        // and the output register is (or is becoming) free.
        w_to_out    = wr_en && (!r_valid || w_pop) && w_mem_empty;
        w_to_mem    = wr_en && !w_to_out;
        w_refill    = w_pop && !w_mem_empty;
    end

    // Storage array: no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_to_mem) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_count <= r_count + CNT_W'(wr_en) - CNT_W'(w_pop);
            if (w_to_mem) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_refill) begin
                r_data   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_valid  <= 1'b1;
            end else if (w_to_out) begin
                r_data  <= wr_data;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rd_valid = r_valid;
    assign rd_data  = r_data;
    assign count    = r_count;

    // Returned data must always find room: the sequencer only requests what fits.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && (r_count == CNT_W'(DEPTH))));

endmodule : scanout_fifo
`default_nettype wire

// File: rtl/scanout_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : scanout_burst_reader
// Description : Streams one frame buffer out of HPS SDRAM over an Avalon-MM
//               burst read port into a FIFO, presented as a valid/ready word
//               stream. A burst is requested only when the FIFO has room for
//               every word already in flight plus the new burst.
// Ports       : clk, reset                 - clock, async active-high reset
//               frame_base, frame_words,
//               start                      - frame request (sampled on start)
//               clear_flags, frame_late    - sticky late-start flag
//               active                     - frame in progress
//               avm_*                      - Avalon-MM burst read master
//               out_data/out_valid/out_ready - word stream to the formatter
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_burst_reader
    import scanout_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int COUNT_W    = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  frame_base,
    input  logic [COUNT_W-1:0] frame_words,
    input  logic               start,
    input  logic               clear_flags,
    output logic               active,
    output logic               frame_late,
    output logic [ADDR_W-1:0]  avm_address,
    output logic [BC_W-1:0]    avm_burstcount,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_readdatavalid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // One spare bit so the free-space subtraction can never wrap.
    localparam int SUM_W = CNT_W + 1;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [COUNT_W-1:0] r_remaining;
    logic [CNT_W-1:0]   r_outstanding;
    logic               r_read;
    logic [ADDR_W-1:0]  r_avm_address;
    logic [BC_W-1:0]    r_burstcount;
    logic               r_frame_late;

    logic [CNT_W-1:0]   w_fifo_count;
    logic [BC_W-1:0]    w_len;
    logic [SUM_W-1:0]   w_free;
    logic               w_space_ok;
    logic               w_accept;
    logic               w_last_burst;
    logic [CNT_W-1:0]   w_outstanding_nxt;

    always_comb begin
        w_len = (r_remaining < COUNT_W'(BURST_LEN)) ? r_remaining[BC_W-1:0]
                                                    : BC_W'(BURST_LEN);
        // Words stored plus words still in flight never exceed FIFO_DEPTH.
        w_free = SUM_W'(FIFO_DEPTH) - SUM_W'(w_fifo_count) - SUM_W'(r_outstanding);
        w_space_ok   = (w_free >= SUM_W'(w_len));
        w_accept     = r_read && !avm_waitrequest;
        w_last_burst = (r_remaining == COUNT_W'(r_burstcount));
        // Accept and return in the same cycle apply both deltas.
        w_outstanding_nxt = r_outstanding
                          + (w_accept ? CNT_W'(r_burstcount) : CNT_W'(0))
                          - (avm_readdatavalid ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_read        <= 1'b0;
            r_avm_address <= '0;
            r_burstcount  <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            case (r_state)
                IDLE: begin
                    if (start && (frame_words != '0)) begin
                        r_addr      <= frame_base;
                        r_remaining <= frame_words;
                        r_state     <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (w_space_ok) begin
                        r_avm_address <= r_addr;
                        r_burstcount  <= w_len;
                        r_read        <= 1'b1;
                        r_state       <= REQ;
                    end
                end
                REQ: begin
                    // Address, burstcount and read stay frozen while stalled.
                    if (w_accept) begin
                        r_read      <= 1'b0;
                        r_addr      <= r_addr + ADDR_W'(r_burstcount);
                        r_remaining <= r_remaining - COUNT_W'(r_burstcount);
                        r_state     <= w_last_burst ? DRAIN : WAIT_SPACE;
                    end
                end
                DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A new start can only be honoured from IDLE; a set in the same cycle
    // as a clear must survive so the overrun is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_late <= 1'b0;
        end else if (start && (r_state != IDLE)) begin
            r_frame_late <= 1'b1;
        end else if (clear_flags) begin
            r_frame_late <= 1'b0;
        end
    end

    scanout_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (avm_readdatavalid),
        .wr_data  (avm_readdata),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .count    (w_fifo_count)
    );

    assign active         = (r_state != IDLE);
    assign frame_late     = r_frame_late;
    assign avm_address    = r_avm_address;
    assign avm_burstcount = r_burstcount;
    assign avm_read       = r_read;

endmodule : scanout_burst_reader
`default_nettype wire

// File: tb/tb_scanout_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanout_burst_reader
// Description : Directed self-checking bench for scanout_burst_reader with a
//               64-entry FIFO. An Avalon slave model returns one word per
//               cycle (data derived from the word address) and a consumer
//               compares every streamed word against the expected frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scanout_burst_reader;
    import scanout_pkg::*;

    localparam int FIFO_DEPTH = 64;
    localparam int COUNT_W    = 24;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  frame_base;
    logic [COUNT_W-1:0] frame_words;
    logic               start;
    logic               clear_flags;
    logic               active;
    logic               frame_late;
    logic [ADDR_W-1:0]  avm_address;
    logic [BC_W-1:0]    avm_burstcount;
    logic               avm_read;
    logic               avm_waitrequest;
    logic [DATA_W-1:0]  avm_readdata;
    logic               avm_readdatavalid;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;

    always #5 clk = ~clk;

    scanout_burst_reader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .COUNT_W    (COUNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_base        (frame_base),
        .frame_words       (frame_words),
        .start             (start),
        .clear_flags       (clear_flags),
        .active            (active),
        .frame_late        (frame_late),
        .avm_address       (avm_address),
        .avm_burstcount    (avm_burstcount),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [ADDR_W-1:0] a);
        return {32'hCAFE_0000 ^ {3'b000, a}, ~{3'b000, a}};
    endfunction

    // Slave / consumer model state
    logic [ADDR_W-1:0] pend_q[$];
    logic [63:0]       exp_q[$];
    logic [ADDR_W-1:0] blog_addr[$];
    int                blog_len[$];
    int                blog_cons[$];
    int                ret_budget  = 1000000;
    int                cons_budget = -1;
    int                consumed    = 0;
    int                wait_left   = 0;
    int                stall_cnt   = 0;
    logic [ADDR_W-1:0] stall_addr  = '0;
    logic [BC_W-1:0]   stall_bc    = '0;

    // Everything facing the DUT changes on the falling edge only.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        out_ready         = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
                avm_readdatavalid = 1'b0;
                avm_waitrequest   = 1'b0;
                out_ready         = 1'b0;
                continue;
            end
            // consumer
            out_ready = (cons_budget != 0);
            if (out_valid && out_ready) begin
                consumed++;
                if (cons_budget > 0) cons_budget--;
                check("word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("stream_word", out_data, exp_q.pop_front());
            end
            // read data return, one word per cycle
            if (pend_q.size() != 0 && ret_budget > 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = data_of(pend_q.pop_front());
                ret_budget--;
            end else begin
                avm_readdatavalid = 1'b0;
            end
            // request side
            if (avm_read && wait_left > 0) begin
                avm_waitrequest = 1'b1;
                wait_left--;
                stall_cnt++;
                check("stall_addr", 64'(avm_address), 64'(stall_addr));
                check("stall_bc", 64'(avm_burstcount), 64'(stall_bc));
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (avm_read && !avm_waitrequest) begin
                logic [ADDR_W-1:0] a;
                blog_addr.push_back(avm_address);
                blog_len.push_back(int'(avm_burstcount));
                blog_cons.push_back(consumed);
                for (int i = 0; i < int'(avm_burstcount); i++) begin
                    a = avm_address + ADDR_W'(i);
                    pend_q.push_back(a);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [ADDR_W-1:0] base, input int words,
                               input bit push_exp, input bit timing_chk);
        logic [ADDR_W-1:0] a;
        frame_base  = base;
        frame_words = COUNT_W'(words);
        start       = 1'b1;
        if (push_exp) begin
            for (int i = 0; i < words; i++) begin
                a = base + ADDR_W'(i);
                exp_q.push_back(data_of(a));
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (timing_chk) begin
            check("active_at_n1", 64'(active), 64'd1);
            check("read_low_at_n1", 64'(avm_read), 64'd0);
            @(posedge clk); #1;
            check("read_at_n2", 64'(avm_read), 64'd1);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (active && n < 2000) begin @(posedge clk); #1; n++; end
        check({tag, " active_fall"}, 64'(active), 64'd0);
        check({tag, " returns_done"}, 64'(pend_q.size()), 64'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        check({tag, " words_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_log();
        blog_addr.delete();
        blog_len.delete();
        blog_cons.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " avm_read"}, 64'(avm_read), 64'd0);
        check({tag, " avm_address"}, 64'(avm_address), 64'd0);
        check({tag, " avm_burstcount"}, 64'(avm_burstcount), 64'd0);
        check({tag, " active"}, 64'(active), 64'd0);
        check({tag, " frame_late"}, 64'(frame_late), 64'd0);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " out_data"}, out_data, 64'd0);
    endtask

    initial begin
        start       = 1'b0;
        clear_flags = 1'b0;
        frame_base  = '0;
        frame_words = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Zero-length request is a no-op
        start_frame(29'h55, 0, 1'b0, 1'b0);
        check("zero_len active", 64'(active), 64'd0);
        @(posedge clk); #1;
        check("zero_len read", 64'(avm_read), 64'd0);
        check("zero_len late", 64'(frame_late), 64'd0);

        // 64 words from 0x100: two full bursts
        clear_log();
        start_frame(29'h100, 64, 1'b1, 1'b1);
        wait_done("t64");
        check("t64 nbursts", 64'(blog_addr.size()), 64'd2);
        check("t64 b0 addr", 64'(blog_addr[0]), 64'h100);
        check("t64 b0 len", 64'(blog_len[0]), 64'd32);
        check("t64 b1 addr", 64'(blog_addr[1]), 64'h120);
        check("t64 b1 len", 64'(blog_len[1]), 64'd32);

        // 40 words straddling the top of the address space
        clear_log();
        start_frame(29'h1FFF_FFF0, 40, 1'b1, 1'b1);
        wait_done("t40");
        check("t40 nbursts", 64'(blog_addr.size()), 64'd2);
        check("t40 b0 addr", 64'(blog_addr[0]), 64'h1FFF_FFF0);
        check("t40 b0 len", 64'(blog_len[0]), 64'd32);
        check("t40 b1 addr", 64'(blog_addr[1]), 64'h10);
        check("t40 b1 len", 64'(blog_len[1]), 64'd8);

        // Back-pressure: FIFO fills after two bursts, third waits for space
        clear_log();
        cons_budget = 0;
        consumed    = 0;
        start_frame(29'h2000, 96, 1'b1, 1'b1);
        repeat (120) @(posedge clk);
        #1;
        check("bp nbursts_stalled", 64'(blog_addr.size()), 64'd2);
        check("bp out_valid", 64'(out_valid), 64'd1);
        check("bp consumed", 64'(consumed), 64'd0);
        cons_budget = 32;
        for (int n = 0; n < 500 && blog_addr.size() < 3; n++) begin @(posedge clk); #1; end
        check("bp third_burst", 64'(blog_addr.size()), 64'd3);
        check("bp consumed_before_third", 64'(blog_cons[2]), 64'd32);
        check("bp third addr", 64'(blog_addr[2]), 64'h2040);
        cons_budget = -1;
        wait_done("bp");

        // Wait-request held for five cycles on the first burst
        clear_log();
        stall_cnt  = 0;
        stall_addr = 29'h300;
        stall_bc   = 8'd32;
        wait_left  = 5;
        start_frame(29'h300, 64, 1'b1, 1'b1);
        wait_done("wr");
        check("wr stall_cycles", 64'(stall_cnt), 64'd5);
        check("wr nbursts", 64'(blog_addr.size()), 64'd2);
        check("wr b0 addr", 64'(blog_addr[0]), 64'h300);
        check("wr b1 addr", 64'(blog_addr[1]), 64'h320);

        // Start while busy is ignored and flagged
        clear_log();
        start_frame(29'h400, 64, 1'b1, 1'b1);
        check("late before", 64'(frame_late), 64'd0);
        start_frame(29'h900, 16, 1'b0, 1'b0);
        check("late set", 64'(frame_late), 64'd1);
        clear_flags = 1'b1;
        start_frame(29'h900, 16, 1'b0, 1'b0);
        clear_flags = 1'b0;
        check("late set_beats_clear", 64'(frame_late), 64'd1);
        wait_done("late");
        check("late nbursts", 64'(blog_addr.size()), 64'd2);
        check("late b1 addr", 64'(blog_addr[1]), 64'h420);
        check("late held", 64'(frame_late), 64'd1);
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        check("late cleared", 64'(frame_late), 64'd0);

        // Reset mid-frame with 16 words outstanding and 48 in the FIFO
        clear_log();
        cons_budget = 0;
        ret_budget  = 48;
        start_frame(29'h800, 64, 1'b1, 1'b1);
        for (int n = 0; n < 500 && !(blog_addr.size() == 2 && ret_budget == 0); n++) begin
            @(posedge clk); #1;
        end
        check("rst two_bursts", 64'(blog_addr.size()), 64'd2);
        check("rst in_flight", 64'(pend_q.size()), 64'd16);
        check("rst fifo_has_data", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("rst async active", 64'(active), 64'd0);
        @(posedge clk); #1;
        check_reset_outputs("rst");
        exp_q.delete();
        ret_budget  = 1000000;
        cons_budget = -1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        clear_log();
        start_frame(29'hA00, 40, 1'b1, 1'b1);
        wait_done("post_rst");
        check("post_rst nbursts", 64'(blog_addr.size()), 64'd2);
        check("post_rst b0 addr", 64'(blog_addr[0]), 64'hA00);
        check("post_rst b1 len", 64'(blog_len[1]), 64'd8);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_scanout_burst_reader
`default_nettype wire
